// File: rtl/sram_responder.sv
// External-SRAM responder: latches one CPU request, waits a fixed number of
// cycles, performs the byte-laned access and answers with a one-cycle R pulse.
module sram_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       Data_from_CPU,
    output logic [15:0]       Data_to_CPU,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    output logic              R,
    input  logic              Init_WE,
    input  logic [ADDR_W-1:0] Init_ADDR,
    input  logic [15:0]       Init_Data
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                ub_q;
    logic                lb_q;
    logic                isWr_q;
    logic [15:0]         wdata_q;
    logic [15:0]         rdata_q;
    logic                r_q;
    logic [15:0]         mem [DEPTH];

    logic                wrEn_d;
    logic [15:0]         wrWord_d;
    logic                request;
    logic                unusedAddrBits;

    // Upper address bits are deliberately ignored so addresses alias.
    assign unusedAddrBits = ^ADDR[15:ADDR_W];
    assign request        = !CE && (!OE || !WE);
    assign Data_to_CPU    = rdata_q;
    assign R              = r_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            isWr_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            r_q     <= 1'b0;
        end else begin
            r_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        idx_q   <= ADDR[ADDR_W-1:0];
                        ub_q    <= UB;
                        lb_q    <= LB;
                        wdata_q <= Data_from_CPU;
                        isWr_q  <= !WE;
                        cnt_q   <= WS;
                        state_q <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    // Dropping CE while waiting abandons the request silently.
                    if (CE) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_ACCESS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!isWr_q) begin
                        rdata_q <= {ub_q ? 8'h00 : mem[idx_q][15:8],
                                    lb_q ? 8'h00 : mem[idx_q][7:0]};
                    end
                    r_q     <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (CE || (OE && WE)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wrEn_d   = (state_q == S_ACCESS) && isWr_q;
        wrWord_d = {ub_q ? mem[idx_q][15:8] : wdata_q[15:8],
                    lb_q ? mem[idx_q][7:0]  : wdata_q[7:0]};
    end

    // Init write is issued last so it overrides a CPU write to the same word.
    always_ff @(posedge Clk) begin
        if (wrEn_d) begin
            mem[idx_q] <= wrWord_d;
        end
        if (Init_WE) begin
            mem[Init_ADDR] <= Init_Data;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (2 and 0 wait states) checked
// against a word-array model through directed and randomized accesses.
module tb_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] dataIn;
    logic        ceA;
    logic        ceB;
    logic        ub;
    logic        lb;
    logic        oe;
    logic        we;
    logic        initWe;
    logic [7:0]  initAddr;
    logic [15:0] initData;
    logic [15:0] dataOutA;
    logic [15:0] dataOutB;
    logic        rA;
    logic        rB;

    int          checks   = 0;
    int          failures = 0;
    int          pulses;
    logic [15:0] mdl [2][256];
    logic [15:0] lastRd [2];

    always #5 clock = ~clock;

    sram_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut (
        .Clk(clock), .Reset(reset), .ADDR(addr), .Data_from_CPU(dataIn),
        .Data_to_CPU(dataOutA), .CE(ceA), .UB(ub), .LB(lb), .OE(oe), .WE(we),
        .R(rA), .Init_WE(initWe), .Init_ADDR(initAddr), .Init_Data(initData)
    );

    sram_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .Clk(clock), .Reset(reset), .ADDR(addr), .Data_from_CPU(dataIn),
        .Data_to_CPU(dataOutB), .CE(ceB), .UB(ub), .LB(lb), .OE(oe), .WE(we),
        .R(rB), .Init_WE(initWe), .Init_ADDR(initAddr), .Init_Data(initData)
    );

    function automatic logic rOf(input bit sel);
        return sel ? rB : rA;
    endfunction

    function automatic logic [15:0] dataOf(input bit sel);
        return sel ? dataOutB : dataOutA;
    endfunction

    function automatic logic [15:0] laneRead(input logic [15:0] w, input bit u, input bit l);
        return {u ? 8'h00 : w[15:8], l ? 8'h00 : w[7:0]};
    endfunction

    function automatic logic [15:0] laneWrite(input logic [15:0] old, input logic [15:0] nw,
                                              input bit u, input bit l);
        return {u ? old[15:8] : nw[15:8], l ? old[7:0] : nw[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyInit(input logic [7:0] idx, input logic [15:0] data);
        @(negedge clock);
        initWe   = 1'b1;
        initAddr = idx;
        initData = data;
        @(posedge clock);
        mdl[0][idx] = data;
        mdl[1][idx] = data;
        @(negedge clock);
        initWe = 1'b0;
    endtask

    // One complete CPU access on instance sel; initAt==ws fires an Init write
    // on the access edge itself.
    task automatic applyStimulus(input bit sel, input logic [15:0] addrV, input logic [15:0] dataV,
                                 input bit isWr, input bit both, input bit ubV, input bit lbV,
                                 input int initAt, input logic [7:0] iIdx, input logic [15:0] iData);
        int          ws;
        logic [7:0]  idx;
        logic [15:0] expRd;
        ws  = sel ? 0 : 2;
        idx = addrV[7:0];
        @(negedge clock);
        addr   = addrV;
        dataIn = dataV;
        ub     = ubV;
        lb     = lbV;
        we     = isWr ? 1'b0 : 1'b1;
        oe     = (!isWr || both) ? 1'b0 : 1'b1;
        if (sel) ceB = 1'b0; else ceA = 1'b0;
        @(posedge clock);
        for (int j = 0; j <= ws; j++) begin
            @(negedge clock);
            checkOutput("rEarly", {15'h0, rOf(sel)}, 16'h0000);
            addr   = 16'($urandom);
            dataIn = 16'($urandom);
            ub     = 1'($urandom);
            lb     = 1'($urandom);
            if (j == initAt) begin
                initWe   = 1'b1;
                initAddr = iIdx;
                initData = iData;
            end
            @(posedge clock);
        end
        expRd = laneRead(mdl[sel][idx], ubV, lbV);
        if (isWr) mdl[sel][idx] = laneWrite(mdl[sel][idx], dataV, ubV, lbV);
        else lastRd[sel] = expRd;
        if (initAt == ws) begin
            mdl[0][iIdx] = iData;
            mdl[1][iIdx] = iData;
        end
        @(negedge clock);
        initWe = 1'b0;
        checkOutput("rPulse", {15'h0, rOf(sel)}, 16'h0001);
        checkOutput(isWr ? "dataAfterWr" : "rdData", dataOf(sel), lastRd[sel]);
        ceA = 1'b1;
        ceB = 1'b1;
        oe  = 1'b1;
        we  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rFall", {15'h0, rOf(sel)}, 16'h0000);
        checkOutput("dataHold", dataOf(sel), lastRd[sel]);
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset  = 1'b1;
        addr   = '0;
        dataIn = '0;
        ceA    = 1'b1;
        ceB    = 1'b1;
        ub     = 1'b0;
        lb     = 1'b0;
        oe     = 1'b1;
        we     = 1'b1;
        initWe = 1'b0;
        initAddr = '0;
        initData = '0;
        lastRd[0] = '0;
        lastRd[1] = '0;
        #12;
        checkOutput("resetRA", {15'h0, rA}, 16'h0000);
        checkOutput("resetDataA", dataOutA, 16'h0000);
        checkOutput("resetRB", {15'h0, rB}, 16'h0000);
        checkOutput("resetDataB", dataOutB, 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            applyInit(8'(i), (i == 8'h20 || i == 8'h30) ? 16'h0000 : 16'($urandom));
        end

        // Preload then full read
        applyInit(8'h10, 16'h1234);
        applyStimulus(0, 16'h0010, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("preloadRead", dataOutA, 16'h1234);

        // Lower-byte write, then full and upper-only reads
        applyStimulus(0, 16'h0010, 16'hABCD, 1, 0, 1, 0, -1, 8'h00, 16'h0000);
        applyStimulus(0, 16'h0010, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("byteWriteRead", dataOutA, 16'h12CD);
        applyStimulus(0, 16'h0010, 16'h0000, 0, 0, 0, 1, -1, 8'h00, 16'h0000);
        checkOutput("upperOnlyRead", dataOutA, 16'h1200);

        // Aliased address with both strobes low is a write
        applyStimulus(0, 16'h0110, 16'h5555, 1, 1, 0, 0, -1, 8'h00, 16'h0000);
        applyStimulus(0, 16'h0010, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("aliasWrite", dataOutA, 16'h5555);

        // Held strobe gives one pulse; a CE bounce gives a second
        @(negedge clock);
        addr = 16'h0010; ub = 1'b0; lb = 1'b0; oe = 1'b0; we = 1'b1; ceA = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rA) pulses++;
        end
        checkOutput("holdOnePulse", pulses[15:0], 16'd1);
        ceA = 1'b1;
        @(negedge clock);
        ceA = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rA) pulses++;
        end
        checkOutput("retriggerPulse", pulses[15:0], 16'd1);
        checkOutput("holdData", dataOutA, mdl[0][8'h10]);
        lastRd[0] = mdl[0][8'h10];
        ceA = 1'b1; oe = 1'b1;
        @(posedge clock);
        @(posedge clock);

        // Abort in WAIT: no pulse, no write, data unchanged
        @(negedge clock);
        addr = 16'h0020; dataIn = 16'hFFFF; ub = 1'b0; lb = 1'b0; we = 1'b0; oe = 1'b1; ceA = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ceA = 1'b1; we = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rA) pulses++;
        end
        checkOutput("abortNoPulse", pulses[15:0], 16'd0);
        checkOutput("abortData", dataOutA, lastRd[0]);
        applyStimulus(0, 16'h0020, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("abortArray", dataOutA, 16'h0000);

        // Reset during WAIT of a write
        applyStimulus(0, 16'h0010, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        @(negedge clock);
        addr = 16'h0040; dataIn = ~mdl[0][8'h40]; we = 1'b0; oe = 1'b1; ceA = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rstMidR", {15'h0, rA}, 16'h0000);
        checkOutput("rstMidData", dataOutA, 16'h0000);
        ceA = 1'b1; we = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        lastRd[0] = '0;
        lastRd[1] = '0;
        applyStimulus(0, 16'h0040, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);

        // Init collides with CPU write on the access edge
        applyStimulus(0, 16'h0030, 16'h1111, 1, 0, 0, 0, 2, 8'h30, 16'h2222);
        applyStimulus(0, 16'h0030, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("initWinsA", dataOutA, 16'h2222);
        applyStimulus(1, 16'h0031, 16'h1111, 1, 0, 0, 0, 0, 8'h31, 16'h2222);
        applyStimulus(1, 16'h0031, 16'h0000, 0, 0, 0, 0, -1, 8'h00, 16'h0000);
        checkOutput("initWinsB", dataOutB, 16'h2222);

        // Randomized accesses on both instances
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'(i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), -1, 8'h00, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the CPU's external SRAM interface: address, 16-bit data, and active-low CE/UB/LB/OE/WE.
- Holds an on-chip word array.
- Accepts one read or write per request and inserts a programmable number of wait states.
- Signals completion with a one-cycle ready pulse.
- A side init port preloads program/data words before or during CPU operation.

Parameters:
- ADDR_W, 8, index width; depth is 2**ADDR_W words. ADDR[15:ADDR_W] is ignored, so addresses alias.
- WAIT_STATES, 2, extra cycles between request sample and completion (0–15 legal).

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- ADDR  input  16  word address from CPU MAR.
- Data_from_CPU  input  16  write data from CPU MDR.
- Data_to_CPU  output  16  read data, registered.
- CE  input  1  chip enable, active-low.
- UB  input  1  upper byte lane [15:8] enable, active-low.
- LB  input  1  lower byte lane [7:0] enable, active-low.
- OE  input  1  output enable (read request), active-low.
- WE  input  1  write enable (write request), active-low.
- R  output  1  ready; one-cycle completion pulse.
- Init_WE  input  1  preload write strobe, active-high.
- Init_ADDR  input  ADDR_W  preload word index.
- Init_Data  input  16  preload word.

Behaviour:
- Reset (async, active-high):
  - State = IDLE, R = 0, Data_to_CPU = 16'h0000, wait counter = 0.
  - Array contents are not cleared.
  - Reset mid-access abandons the access; no array write occurs.
- Request definition: CE==0 and (OE==0 or WE==0). If WE==0 and OE==0 together, the request is a write (WE has priority).
- FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
- IDLE:
  - On an edge with a valid request, latch idx = ADDR[ADDR_W-1:0], UB, LB, Data_from_CPU and op (rd/wr).
  - Load counter = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to ACCESS.
- WAIT:
  - Counter decrements each edge; when counter reaches 1, go to ACCESS.
  - If CE samples 1 in WAIT, abort: go to IDLE, R stays 0, no write, Data_to_CPU unchanged.
- ACCESS (one cycle); on exit edge go to DONE and:
  - Write: array[idx][15:8] <= data[15:8] if latched UB==0; array[idx][7:0] <= data[7:0] if latched LB==0.
  - Read: Data_to_CPU <= {UB?8'h00:array[idx][15:8], LB?8'h00:array[idx][7:0]}.
  - UB=LB=1 still completes the handshake: no write occurs, and a read returns 0x0000.
- DONE:
  - R = 1 for exactly this cycle.
  - Data_to_CPU is already valid and is held until the next read completes (writes do not change it).
  - Then go to HOLD.
- HOLD:
  - Wait until CE==1, or OE==1 and WE==1, then go to IDLE.
  - This guarantees one access per asserted request; a held-low strobe never retriggers.
- Latency: request sampled at edge k; R high in the cycle following edge k+WAIT_STATES+1. Minimum turnaround between back-to-back requests is one HOLD-exit cycle.
- Inputs changing after the sample edge (ADDR, data, lanes) have no effect on the in-flight access.
- Init port:
  - Init_WE=1 writes the full word array[Init_ADDR] <= Init_Data on the edge, in any FSM state.
  - On the same edge as a CPU write to the same index, the Init write wins entirely.
  - A CPU read in ACCESS on the same edge returns the pre-edge array value.
- Only combinational paths: none; R and Data_to_CPU are registers.

Test Plan:
- Preload via Init: Init_ADDR=8'h10, Init_Data=16'h1234. Then read ADDR=16'h0010 with CE=0, OE=0, UB=LB=0, WAIT_STATES=2 → R pulses 1 cycle, 3 edges after the sample; Data_to_CPU=16'h1234 and held after R falls.
- Byte write: ADDR=16'h0010, Data_from_CPU=16'hABCD, WE=0, UB=1, LB=0; then full read → Data_to_CPU=16'h12CD. Read with LB=1 only enabled upper → 16'h1200.
- Aliasing and priority: ADDR=16'h0110 with WE=0 and OE=0 both low, data 16'h5555 → treated as write to index 8'h10; subsequent read of 16'h0010 returns 16'h5555.
- Hold behaviour: keep CE=0, OE=0 for 20 cycles → exactly one R pulse. Raise CE for 1 cycle, lower again → second R pulse.
- Abort and reset: start write 16'hFFFF to index 8'h20 (prior value 16'h0000), raise CE in WAIT → no R, index 8'h20 still 16'h0000. Assert Reset during WAIT of another write → R=0, Data_to_CPU=0, array unchanged.
- Init collision: CPU write 16'h1111 and Init_WE write 16'h2222 to index 8'h30 on the same ACCESS edge → read returns 16'h2222. With WAIT_STATES=0, the read R pulse comes 1 edge after the sample.
